cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
- Multi-cycle instruction sequencer that drives the 16-bit ALU, register file and memory port.
- Fetches a 16-bit instruction and decodes it into the ALU's 8-bit opcode, register addresses and immediate.
- Waits out the ALU's one-cycle registered latency, then commits writeback, memory access or branch.
- Sits between instruction/data memory and the datapath (register file + ALU).

Parameters:
- PC_WIDTH, 16, width of program counter and instruction address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- instr_req  out  1  instruction fetch request
- instr_addr  out  PC_WIDTH  fetch address (PC)
- instr_ack  in  1  instruction valid on instr_data
- instr_data  in  16  fetched instruction
- alu_opcode  out  8  opcode to ALU
- reg_addr_a  out  4  register file read port A (ALU rdataA)
- reg_addr_b  out  4  register file read port B (ALU rdataB)
- imm_sel  out  1  1 = datapath muxes imm_value onto rdataB
- imm_value  out  16  extended immediate
- psr_in  in  5  ALU flags; bit3 = Z, bit1 = greater
- rf_we  out  1  register write strobe, 1 cycle
- rf_waddr  out  4  write register address
- wb_sel  out  1  0 = ALU result, 1 = memory read data
- mem_req  out  1  data memory request; address = rdataA
- mem_we  out  1  1 = store (data = rdataB), 0 = load
- mem_ack  in  1  data memory completion
- illegal  out  1  1-cycle pulse on undecodable instruction

Behaviour:
- Decided: reset reset, synchronous, active-low; clock clock.
- Reset (reset==0 at a clock edge), including mid-operation:
  - state=FETCH, PC=RESET_PC.
  - All outputs 0.
  - Pending requests are dropped; an ack arriving afterwards is ignored.
- State FETCH:
  - instr_req=1, instr_addr=PC; held until instr_ack.
  - On ack: latch instr_data into IR, go to EXEC.
- State EXEC (decode registered in IR):
  - Drive alu_opcode, reg_addr_a=IR[11:8], reg_addr_b=IR[3:0], imm_sel and imm_value.
  - ALU samples at the end of this cycle.
  - Next state: WB, except memory ops go to MEM and branches go to FETCH directly.
- State WB:
  - alu_opcode, addresses and imm are held stable from EXEC.
  - rf_we=1 and rf_waddr=IR[11:8] if the op writes (see decode).
  - PC<=PC+1; go to FETCH.
- State MEM:
  - mem_req=1, mem_we per op, addresses held; wait for mem_ack.
  - Load ack cycle: rf_we=1, wb_sel=1.
  - On ack: PC<=PC+1, go to FETCH.
- Decode (op=IR[15:12], ext=IR[7:4]):
  - op 0000, register-register: alu_opcode={4'h0,ext}.
    - Write for ext in {1,2,3,5,6,9,D}.
    - CMP (ext B): no write; the ALU updates its flags.
  - op 0101 ADDI: alu_opcode=8'h05, imm=sign-extend IR[7:0], write.
  - op 1101 MOVI: alu_opcode=8'h0D, imm=zero-extend IR[7:0], write.
  - op 1111 LUI: alu_opcode=8'hF0, imm={8'h00,IR[7:0]}, write.
  - op 1000 shifts:
    - ext 4: LSH register, alu_opcode=8'h84.
    - ext 0 / 1: LSHI left / right, alu_opcode=8'h80 / 8'h81, imm=IR[3:0] zero-extended.
    - All shifts write.
  - op 0100 memory:
    - ext 0: LOAD, rf_waddr=IR[11:8], reg_addr_a=IR[3:0].
    - ext 4: STOR, reg_addr_a=IR[3:0] (address), reg_addr_b=IR[11:8] (data).
  - op 1100 Bcond, cond=IR[11:8]:
    - 0 EQ: psr_in[3]=1.
    - 1 NE: psr_in[3]=0.
    - 6 GT: psr_in[1]=1.
    - E: always.
    - Taken: PC<=PC+sext(IR[7:0]). Not taken: PC<=PC+1.
    - Evaluated in EXEC.
  - Anything else: illegal=1 for one cycle in EXEC, treated as NOP (PC+1, FETCH).
- Arithmetic and timing:
  - PC wraps modulo 2^PC_WIDTH.
  - Branch displacement is two's-complement.
  - Acks are accepted only in their own state.
  - A simultaneous ack and reset: reset wins.
  - Minimum CPI: 3 for ALU ops (FETCH with same-cycle ack, EXEC, WB); 2 for branches.

Decomposition:
- Shared package `cpu_pkg` holds:
  - State enum {FETCH, EXEC, WB, MEM}.
  - Major op constants (OP_RR, OP_ADDI, OP_MEM, OP_SHIFT, OP_BCOND, OP_MOVI, OP_LUI).
  - ALU ext codes shared with the ALU.
  - Condition codes.
- One sub-module `instr_decoder`, purely combinational. It maps IR to:
  - alu_opcode, imm_sel and imm_value;
  - the write flag and op class;
  - legality.
- The FSM, PC and IR live in cpu_control_fsm.

Test Plan:
1. Reset: hold reset=0 for 2 cycles during a pending MEM state -> all outputs 0, instr_addr=0 and instr_req=1 on the first cycle after release.
2. ALU op: IR=16'h0152 (ADD R1,R2), instr_ack immediate -> alu_opcode=8'h05, reg_addr_a=1, reg_addr_b=2 in EXEC; rf_we=1, rf_waddr=1 exactly one cycle later; PC=1.
3. Immediate ops:
   - IR=16'h53FF (ADDI R3,-1) -> imm_sel=1, imm_value=16'hFFFF.
   - IR=16'hF4AB (LUI) -> alu_opcode=8'hF0, imm_value=16'h00AB.
4. Load with 3-cycle mem_ack delay: IR=16'h4507 -> mem_req held 3 cycles, mem_we=0; rf_we=1, wb_sel=1, rf_waddr=5 on the ack cycle.
5. Branches at PC=10:
   - IR=16'hC0FC with psr_in[3]=1 -> next instr_addr=6.
   - Same IR with psr_in[3]=0 -> next instr_addr=11.
   - IR=16'hCE02 at PC=16'hFFFF -> instr_addr=1 (wrap).
6. Illegal and CMP:
   - IR=16'h7000 -> illegal pulses 1 cycle, rf_we stays 0, PC increments.
   - CMP IR=16'h01B2 -> no rf_we.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: sequencer states,
// major opcodes, ALU ext codes, branch conditions and the decoded-instruction bundle.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WB,
        MEM
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } op_class_t;

    // Major opcodes, IR[15:12]
    localparam logic [3:0] OP_RR    = 4'h0;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_LUI   = 4'hF;

    // Register-register ext codes, IR[7:4]; these double as the ALU's low opcode nibble
    localparam logic [3:0] EXT_AND  = 4'h1;
    localparam logic [3:0] EXT_OR   = 4'h2;
    localparam logic [3:0] EXT_XOR  = 4'h3;
    localparam logic [3:0] EXT_ADD  = 4'h5;
    localparam logic [3:0] EXT_ADDU = 4'h6;
    localparam logic [3:0] EXT_SUB  = 4'h9;
    localparam logic [3:0] EXT_CMP  = 4'hB;
    localparam logic [3:0] EXT_MOV  = 4'hD;

    // Shift and memory ext codes
    localparam logic [3:0] EXT_LSHI_L = 4'h0;
    localparam logic [3:0] EXT_LSHI_R = 4'h1;
    localparam logic [3:0] EXT_LSH    = 4'h4;
    localparam logic [3:0] EXT_LOAD   = 4'h0;
    localparam logic [3:0] EXT_STOR   = 4'h4;

    // ALU opcodes issued for the immediate forms
    localparam logic [7:0] ALU_ADDI = 8'h05;
    localparam logic [7:0] ALU_MOVI = 8'h0D;
    localparam logic [7:0] ALU_LUI  = 8'hF0;
    localparam logic [7:0] ALU_LSH  = 8'h84;

    // Branch conditions, IR[11:8]
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_UC = 4'hE;

    typedef struct packed {
        logic [7:0]  alu_opcode;
        logic [3:0]  reg_a;
        logic [3:0]  reg_b;
        logic        imm_sel;
        logic [15:0] imm_value;
        logic        writes;
        op_class_t   op_class;
        logic        legal;
    } decode_t;

    // psr bit3 is Z, bit1 is "greater"
    function automatic logic branch_taken(input logic [3:0] cond, input logic [4:0] psr);
        case (cond)
            COND_EQ: return psr[3];
            COND_NE: return ~psr[3];
            COND_GT: return psr[1];
            COND_UC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the sequencer (master) and memories/datapath (slave).
interface cpu_control_fsm_if #(
    parameter int PC_WIDTH = 16
);
    logic                instr_req;
    logic [PC_WIDTH-1:0] instr_addr;
    logic                instr_ack;
    logic [15:0]         instr_data;
    logic [7:0]          alu_opcode;
    logic [3:0]          reg_addr_a;
    logic [3:0]          reg_addr_b;
    logic                imm_sel;
    logic [15:0]         imm_value;
    logic [4:0]          psr_in;
    logic                rf_we;
    logic [3:0]          rf_waddr;
    logic                wb_sel;
    logic                mem_req;
    logic                mem_we;
    logic                mem_ack;
    logic                illegal;

    modport master (
        output instr_req, instr_addr, alu_opcode, reg_addr_a, reg_addr_b,
               imm_sel, imm_value, rf_we, rf_waddr, wb_sel, mem_req, mem_we, illegal,
        input  instr_ack, instr_data, psr_in, mem_ack
    );

    modport slave (
        input  instr_req, instr_addr, alu_opcode, reg_addr_a, reg_addr_b,
               imm_sel, imm_value, rf_we, rf_waddr, wb_sel, mem_req, mem_we, illegal,
        output instr_ack, instr_data, psr_in, mem_ack
    );
endinterface

// File: rtl/cpu_control_fsm_instr_decoder.sv
// Purely combinational instruction decoder: IR -> ALU controls, operand
// selects, immediate, write flag, op class and legality.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output decode_t     dec
);
    logic [3:0] op;
    logic [3:0] ext;

    assign op  = instr[15:12];
    assign ext = instr[7:4];

    // Anything not matched below stays CLS_ILLEGAL and is run as a NOP
    always_comb begin
        dec          = '0;
        dec.reg_a    = instr[11:8];
        dec.reg_b    = instr[3:0];
        dec.op_class = CLS_ILLEGAL;
        case (op)
            OP_RR: begin
                if (ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_ADDU, EXT_SUB, EXT_MOV}) begin
                    dec.alu_opcode = {4'h0, ext};
                    dec.writes     = 1'b1;
                    dec.op_class   = CLS_ALU;
                end else if (ext == EXT_CMP) begin
                    dec.alu_opcode = {4'h0, ext};
                    dec.op_class   = CLS_ALU;
                end
            end
            OP_ADDI: begin
                dec.alu_opcode = ALU_ADDI;
                dec.imm_sel    = 1'b1;
                dec.imm_value  = {{8{instr[7]}}, instr[7:0]};
                dec.writes     = 1'b1;
                dec.op_class   = CLS_ALU;
            end
            OP_MOVI: begin
                dec.alu_opcode = ALU_MOVI;
                dec.imm_sel    = 1'b1;
                dec.imm_value  = {8'h00, instr[7:0]};
                dec.writes     = 1'b1;
                dec.op_class   = CLS_ALU;
            end
            OP_LUI: begin
                dec.alu_opcode = ALU_LUI;
                dec.imm_sel    = 1'b1;
                dec.imm_value  = {8'h00, instr[7:0]};
                dec.writes     = 1'b1;
                dec.op_class   = CLS_ALU;
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    dec.alu_opcode = ALU_LSH;
                    dec.writes     = 1'b1;
                    dec.op_class   = CLS_ALU;
                end else if (ext == EXT_LSHI_L || ext == EXT_LSHI_R) begin
                    dec.alu_opcode = {4'h8, ext};
                    dec.imm_sel    = 1'b1;
                    dec.imm_value  = {12'h000, instr[3:0]};
                    dec.writes     = 1'b1;
                    dec.op_class   = CLS_ALU;
                end
            end
            OP_MEM: begin
                if (ext == EXT_LOAD) begin
                    dec.reg_a    = instr[3:0];
                    dec.writes   = 1'b1;
                    dec.op_class = CLS_LOAD;
                end else if (ext == EXT_STOR) begin
                    dec.reg_a    = instr[3:0];
                    dec.reg_b    = instr[11:8];
                    dec.op_class = CLS_STORE;
                end
            end
            OP_BCOND: begin
                if (instr[11:8] inside {COND_EQ, COND_NE, COND_GT, COND_UC}) begin
                    dec.op_class = CLS_BRANCH;
                end
            end
            default: ;
        endcase
        dec.legal = (dec.op_class != CLS_ILLEGAL);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> WB/MEM -> FETCH,
// branches return to FETCH straight from EXEC. Outputs are registered, except
// the load write strobe which must coincide with the memory's ack cycle.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)
(
    input  logic              clock,
    input  logic              reset,
    cpu_control_fsm_if.master bus
);
    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                rf_we_q;
    logic                load_pending;
    decode_t             dec;
    logic [15:0]         dec_src;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_branch;
    logic [PC_WIDTH-1:0] pc_next;
    logic                taken;

    // In FETCH the incoming word is decoded so EXEC controls can be registered
    // on the ack edge; afterwards the decoder looks at the latched IR.
    assign dec_src = (state == FETCH) ? bus.instr_data : ir;

    instr_decoder u_decoder (
        .instr (dec_src),
        .dec   (dec)
    );

    assign pc_inc    = pc + PC_WIDTH'(1);
    assign pc_branch = pc + {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};
    assign taken     = branch_taken(ir[11:8], bus.psr_in);
    assign pc_next   = (dec.op_class == CLS_BRANCH && taken) ? pc_branch : pc_inc;

    assign bus.rf_we = rf_we_q | (load_pending & bus.mem_ack & reset);

    // Sequencer state, PC/IR and all registered control outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            ir             <= '0;
            rf_we_q        <= 1'b0;
            load_pending   <= 1'b0;
            bus.instr_req  <= 1'b0;
            bus.instr_addr <= '0;
            bus.alu_opcode <= '0;
            bus.reg_addr_a <= '0;
            bus.reg_addr_b <= '0;
            bus.imm_sel    <= 1'b0;
            bus.imm_value  <= '0;
            bus.rf_waddr   <= '0;
            bus.wb_sel     <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.illegal    <= 1'b0;
        end else begin
            bus.illegal <= 1'b0;
            rf_we_q     <= 1'b0;
            case (state)
                FETCH: begin
                    bus.instr_req  <= 1'b1;
                    bus.instr_addr <= pc;
                    if (bus.instr_req && bus.instr_ack) begin
                        ir             <= bus.instr_data;
                        bus.instr_req  <= 1'b0;
                        bus.alu_opcode <= dec.alu_opcode;
                        bus.reg_addr_a <= dec.reg_a;
                        bus.reg_addr_b <= dec.reg_b;
                        bus.imm_sel    <= dec.imm_sel;
                        bus.imm_value  <= dec.imm_value;
                        bus.illegal    <= ~dec.legal;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    case (dec.op_class)
                        CLS_BRANCH, CLS_ILLEGAL: begin
                            pc             <= pc_next;
                            bus.instr_req  <= 1'b1;
                            bus.instr_addr <= pc_next;
                            state          <= FETCH;
                        end
                        CLS_LOAD: begin
                            bus.mem_req  <= 1'b1;
                            bus.mem_we   <= 1'b0;
                            bus.wb_sel   <= 1'b1;
                            bus.rf_waddr <= ir[11:8];
                            load_pending <= 1'b1;
                            state        <= MEM;
                        end
                        CLS_STORE: begin
                            bus.mem_req <= 1'b1;
                            bus.mem_we  <= 1'b1;
                            state       <= MEM;
                        end
                        default: begin
                            rf_we_q      <= dec.writes;
                            bus.rf_waddr <= ir[11:8];
                            bus.wb_sel   <= 1'b0;
                            state        <= WB;
                        end
                    endcase
                end
                WB: begin
                    pc             <= pc_inc;
                    bus.instr_req  <= 1'b1;
                    bus.instr_addr <= pc_inc;
                    state          <= FETCH;
                end
                MEM: begin
                    if (bus.mem_req && bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.wb_sel     <= 1'b0;
                        load_pending   <= 1'b0;
                        pc             <= pc_inc;
                        bus.instr_req  <= 1'b1;
                        bus.instr_addr <= pc_inc;
                        state          <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: stimulus pushes hand-computed
// expectations into queues, a negedge monitor pops them as the DUT presents
// fetches, EXEC controls, register writes and memory completions.
module tb_cpu_control_fsm;
    import cpu_pkg::*;

    typedef struct packed {
        logic [7:0]  alu;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        sel;
        logic [15:0] imm;
        logic        ill;
    } exec_exp_t;

    typedef struct packed {
        logic [3:0] waddr;
        logic       wbsel;
        logic [7:0] delta;
    } wr_exp_t;

    typedef struct packed {
        logic       we;
        logic [7:0] held;
    } mem_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [15:0] fetch_q[$];
    exec_exp_t   exec_q[$];
    wr_exp_t     wr_q[$];
    mem_exp_t    mem_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    cpu_control_fsm_if #(.PC_WIDTH(16)) bus ();

    cpu_control_fsm #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] allOutputs();
        return {5'b0, bus.instr_req, bus.instr_addr, bus.alu_opcode, bus.reg_addr_a,
                bus.reg_addr_b, bus.imm_sel, bus.imm_value, bus.rf_we, bus.rf_waddr,
                bus.wb_sel, bus.mem_req, bus.mem_we, bus.illegal};
    endfunction

    // Monitor: compare whatever the DUT presents against the queued expectations
    int        cycle      = 0;
    int        exec_cycle = 0;
    int        mem_held   = 0;
    logic      pend_exec  = 1'b0;
    exec_exp_t ee;
    wr_exp_t   we_item;
    mem_exp_t  me;
    logic [15:0] fa;

    always @(negedge clock) begin
        cycle++;
        if (!reset) begin
            pend_exec = 1'b0;
            mem_held  = 0;
        end else begin
            if (pend_exec) begin
                pend_exec  = 1'b0;
                exec_cycle = cycle;
                if (exec_q.size() == 0) begin
                    checkOutput("exec_unexpected", 1, 0);
                end else begin
                    ee = exec_q.pop_front();
                    checkOutput("alu_opcode", bus.alu_opcode, ee.alu);
                    checkOutput("reg_addr_a", bus.reg_addr_a, ee.a);
                    checkOutput("reg_addr_b", bus.reg_addr_b, ee.b);
                    checkOutput("imm_sel", bus.imm_sel, ee.sel);
                    checkOutput("imm_value", bus.imm_value, ee.imm);
                    checkOutput("illegal", bus.illegal, ee.ill);
                end
            end else if (bus.illegal) begin
                checkOutput("illegal_outside_exec", bus.illegal, 0);
            end
            if (bus.instr_req && bus.instr_ack) begin
                pend_exec = 1'b1;
                if (fetch_q.size() == 0) begin
                    checkOutput("fetch_unexpected", 1, 0);
                end else begin
                    fa = fetch_q.pop_front();
                    checkOutput("instr_addr", bus.instr_addr, fa);
                end
            end
            if (bus.mem_req) mem_held++;
            if (bus.mem_req && bus.mem_ack) begin
                if (mem_q.size() == 0) begin
                    checkOutput("mem_unexpected", 1, 0);
                end else begin
                    me = mem_q.pop_front();
                    checkOutput("mem_we", bus.mem_we, me.we);
                    checkOutput("mem_req_cycles", mem_held, me.held);
                end
                mem_held = 0;
            end
            if (bus.rf_we) begin
                if (wr_q.size() == 0) begin
                    checkOutput("rf_we_unexpected", bus.rf_we, 0);
                end else begin
                    we_item = wr_q.pop_front();
                    checkOutput("rf_waddr", bus.rf_waddr, we_item.waddr);
                    checkOutput("wb_sel", bus.wb_sel, we_item.wbsel);
                    checkOutput("rf_we_delay", cycle - exec_cycle, we_item.delta);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitFetch();
        int n = 0;
        while (!bus.instr_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus.instr_req) checkOutput("fetch_timeout", bus.instr_req, 1);
    endtask

    task automatic fetchInstr(input logic [15:0] instr, input logic [4:0] psr);
        waitFetch();
        bus.instr_data = instr;
        bus.psr_in     = psr;
        bus.instr_ack  = 1'b1;
        tick();
        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'h0000;
    endtask

    task automatic applyStimulus(
        input logic [15:0] instr, input logic [4:0] psr, input logic [15:0] faddr,
        input logic [7:0] alu, input logic [3:0] a, input logic [3:0] b,
        input logic sel, input logic [15:0] imm, input logic ill,
        input logic do_wr, input logic [3:0] waddr, input logic wbsel, input logic [7:0] delta,
        input int mem_lat, input logic mem_we
    );
        fetch_q.push_back(faddr);
        exec_q.push_back({alu, a, b, sel, imm, ill});
        if (do_wr) wr_q.push_back({waddr, wbsel, delta});
        if (mem_lat > 0) mem_q.push_back({mem_we, 8'(mem_lat)});
        fetchInstr(instr, psr);
        if (mem_lat > 0) begin
            tick();
            repeat (mem_lat - 1) tick();
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed program: reset mid-load, then ALU, immediate, memory, illegal and branch ops
    initial begin
        bus.instr_ack  = 1'b0;
        bus.instr_data = 16'h0000;
        bus.psr_in     = 5'b0;
        bus.mem_ack    = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        fetch_q.push_back(16'h0000);
        exec_q.push_back({8'h00, 4'h7, 4'h7, 1'b0, 16'h0000, 1'b0});
        fetchInstr(16'h4507, 5'b0);
        tick();
        checkOutput("mem_req_pending", bus.mem_req, 1);
        reset       = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        checkOutput("reset_outputs_cycle0", allOutputs(), 0);
        tick();
        checkOutput("reset_outputs_cycle1", allOutputs(), 0);
        reset = 1'b1;
        tick();
        checkOutput("post_reset_instr_req", bus.instr_req, 1);
        checkOutput("post_reset_instr_addr", bus.instr_addr, 16'h0000);
        checkOutput("post_reset_mem_req", bus.mem_req, 0);
        checkOutput("post_reset_rf_we", bus.rf_we, 0);
        bus.mem_ack = 1'b0;

        //            instr     psr       fetch     alu   a     b     sel   imm       ill   wr    wad   wbs   dly   lat we
        applyStimulus(16'h0152, 5'b00000, 16'h0000, 8'h05, 4'h1, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h1, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'h53FF, 5'b00000, 16'h0001, 8'h05, 4'h3, 4'hF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 4'h3, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'hF4AB, 5'b00000, 16'h0002, 8'hF0, 4'h4, 4'hB, 1'b1, 16'h00AB, 1'b0, 1'b1, 4'h4, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'h4507, 5'b00000, 16'h0003, 8'h00, 4'h7, 4'h7, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h5, 1'b1, 8'd3, 3, 1'b0);
        applyStimulus(16'h7000, 5'b00000, 16'h0004, 8'h00, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'h01B2, 5'b00000, 16'h0005, 8'h0B, 4'h1, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'h4A43, 5'b00000, 16'h0006, 8'h00, 4'h3, 4'hA, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1, 1'b1);
        applyStimulus(16'h8201, 5'b00000, 16'h0007, 8'h80, 4'h2, 4'h1, 1'b1, 16'h0001, 1'b0, 1'b1, 4'h2, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'hD7F0, 5'b00000, 16'h0008, 8'h0D, 4'h7, 4'h0, 1'b1, 16'h00F0, 1'b0, 1'b1, 4'h7, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'hCE01, 5'b00000, 16'h0009, 8'h00, 4'hE, 4'h1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hC0FC, 5'b01000, 16'h000A, 8'h00, 4'h0, 4'hC, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hCE04, 5'b00000, 16'h0006, 8'h00, 4'hE, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hC0FC, 5'b00000, 16'h000A, 8'h00, 4'h0, 4'hC, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hCEF4, 5'b00000, 16'h000B, 8'h00, 4'hE, 4'h4, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hCE02, 5'b00000, 16'hFFFF, 8'h00, 4'hE, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'hC602, 5'b00010, 16'h0001, 8'h00, 4'h6, 4'h2, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);
        applyStimulus(16'h8143, 5'b00000, 16'h0003, 8'h84, 4'h1, 4'h3, 1'b0, 16'h0000, 1'b0, 1'b1, 4'h1, 1'b0, 8'd1, 0, 1'b0);
        applyStimulus(16'hC302, 5'b00000, 16'h0004, 8'h00, 4'h3, 4'h2, 1'b0, 16'h0000, 1'b1, 1'b0, 4'h0, 1'b0, 8'd0, 0, 1'b0);

        waitFetch();
        checkOutput("final_instr_addr", bus.instr_addr, 16'h0005);
        repeat (3) tick();
        checkOutput("fetch_q_drained", fetch_q.size(), 0);
        checkOutput("exec_q_drained", exec_q.size(), 0);
        checkOutput("wr_q_drained", wr_q.size(), 0);
        checkOutput("mem_q_drained", mem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
